uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Parameters
REQ-001 SHALL have parameter BAUD_DIV, default 434, meaning clk cycles per serial bit (50 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 32'd5000000, meaning the maximum number of idle clk cycles allowed between bytes of one command frame.

Interface
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rx_pin  input  1  serial command input, 8N1, idle high.
REQ-007 tx_pin  output  1  serial response output, 8N1, idle high.
REQ-008 addr_o  output  32  bus address.
REQ-009 data_o  output  32  bus write data.
REQ-010 sel_o  output  4  byte enables; always 4'b1111 during an access.
REQ-011 we_o  output  1  write strobe, one-cycle pulse.
REQ-012 rd_o  output  1  read strobe, one-cycle pulse.
REQ-013 data_i  input  32  bus read data, valid exactly one cycle after rd_o.
REQ-014 busy_o  output  1  high whenever the FSM is not in S_CMD.

Function
REQ-015 rx_pin SHALL pass through a 2-FF synchronizer; a start is a synchronized 1->0 edge while the RX engine is idle.
REQ-016 After a start, RX SHALL sample at BAUD_DIV/2 (start re-check, must be 0), then every BAUD_DIV for 8 data bits LSB-first and the stop bit.
REQ-017 Start re-check = 1 -> false start, discarded silently; stop bit = 0 -> framing error, byte dropped, frame aborted to S_CMD with no response.
REQ-018 A received byte SHALL raise a one-cycle internal rx_valid at the stop-bit sample.
REQ-019 TX SHALL emit start(0), 8 data bits LSB-first, stop(1), each bit exactly BAUD_DIV cycles; back-to-back response bytes have no idle gap.
REQ-020 Frame format: cmd byte, 4 address bytes MSB-first, then for write 4 data bytes MSB-first.
REQ-021 Cmd 0x57 ('W') = write; cmd 0x52 ('R') = read; any other cmd -> transmit 0x45 ('E'), then return to S_CMD.
REQ-022 FSM states: S_CMD, S_ADDR (count 0-3), S_WDATA (count 0-3), S_BUS, S_RWAIT, S_RESP, S_ERR.
REQ-023 S_CMD->S_ADDR on a valid cmd; S_ADDR->S_WDATA (write) or S_BUS (read) after the 4th byte; S_WDATA->S_BUS after the 4th byte.
REQ-024 S_BUS SHALL last one cycle, pulsing we_o (write) or rd_o (read) with addr_o/data_o/sel_o stable.
REQ-025 Write: S_BUS->S_RESP, sending 0x4B ('K').
REQ-026 Read: S_BUS->S_RWAIT; S_RWAIT captures data_i on that cycle, then S_RESP sends 4 bytes MSB-first.
REQ-027 S_RESP->S_CMD after the last response stop bit completes; S_ERR->S_CMD after 0x45 completes.
REQ-028 Bytes received in S_BUS, S_RWAIT, S_RESP or S_ERR SHALL be discarded.
REQ-029 In S_ADDR/S_WDATA, TIMEOUT_CYC cycles without rx_valid SHALL abort to S_CMD with no response; the counter restarts on each rx_valid.
REQ-030 addr_o/data_o SHALL hold their last values between accesses; sel_o = 0 outside S_BUS.
REQ-031 Bit-time counters SHALL be at least 16 bits and compare with ==, never wrapping past BAUD_DIV-1.

Reset
REQ-032 On rst=1, at the next edge: tx_pin=1, we_o=0, rd_o=0, sel_o=0, addr_o=0, data_o=0, busy_o=0, FSM=S_CMD, RX/TX engines idle, synchronizer FFs=1.
REQ-033 Reset mid-frame or mid-transmission SHALL abort immediately: no truncated bus strobe, and tx_pin returns high on the next cycle.

Verification
REQ-034 Send 57 00 00 10 00 DE AD BE EF -> one we_o pulse with addr_o=0x00001000, data_o=0xDEADBEEF, sel_o=F, then tx byte 0x4B.
REQ-035 Send 52 00 00 10 04, with data_i=0x12345678 the cycle after rd_o -> tx bytes 12 34 56 78, each 10*BAUD_DIV cycles, no gaps.
REQ-036 Send cmd 0x33 -> tx 0x45, no we_o/rd_o, busy_o low after the stop bit.
REQ-037 Send 57 00 00, then idle TIMEOUT_CYC+1 cycles -> busy_o low, no strobe, no tx activity; a following valid read completes normally.
REQ-038 Send 0x52 with stop bit forced 0 -> no response, FSM in S_CMD; a 1-cycle-low glitch on rx_pin -> no byte accepted.
REQ-039 Assert rst during the second response byte -> tx_pin=1 next cycle, all outputs at reset values, and the next command works.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART-driven bus master: receives W/R command frames over 8N1 serial, performs one
// 32-bit bus access and answers with 'K', the read data, or 'E' for an unknown command.
module uart_bus_master #(
    parameter int unsigned BAUD_DIV    = 434,
    parameter logic [31:0] TIMEOUT_CYC = 32'd5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        rd_o,
    input  logic [31:0] data_i,
    output logic        busy_o
);

    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    localparam logic [2:0] S_CMD   = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_BUS   = 3'd3;
    localparam logic [2:0] S_RWAIT = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // ---------------- receiver ----------------
    logic        rx_s1, rx_s2, rx_s3;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_tick, rx_valid, rx_ferr;

    assign rx_tick  = (rx_cnt == BIT_LAST);
    assign rx_valid = (rx_state == RX_STOP) && rx_tick && rx_s2;
    assign rx_ferr  = (rx_state == RX_STOP) && rx_tick && !rx_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'd0;
        end else begin
            rx_s1 <= rx_pin;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= 16'd0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= 16'd0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_tick) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- transmitter ----------------
    logic        tx_q, tx_active, tx_done, tx_load;
    logic [8:0]  tx_sh;
    logic [3:0]  tx_bit;
    logic [15:0] tx_cnt;
    logic [7:0]  tx_data;

    // tx_done coincides with a same-cycle reload so consecutive bytes have no idle gap
    assign tx_done = tx_active && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
    assign tx_pin  = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q      <= 1'b1;
            tx_active <= 1'b0;
            tx_sh     <= 9'd0;
            tx_bit    <= 4'd0;
            tx_cnt    <= 16'd0;
        end else if (tx_load) begin
            tx_q      <= 1'b0;
            tx_sh     <= {1'b1, tx_data};
            tx_active <= 1'b1;
            tx_bit    <= 4'd0;
            tx_cnt    <= 16'd0;
        end else if (tx_active) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= 16'd0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    tx_q   <= tx_sh[0];
                    tx_sh  <= {1'b1, tx_sh[8:1]};
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- command FSM ----------------
    logic [2:0]  state;
    logic [1:0]  byte_cnt, resp_left;
    logic        is_wr;
    logic [31:0] addr_sh, data_sh, addr_q, data_q, resp_buf, to_cnt;
    logic        cmd_ok;

    assign cmd_ok = (rx_sh == 8'h57) || (rx_sh == 8'h52);

    always_comb begin
        tx_load = 1'b0;
        tx_data = 8'h00;
        case (state)
            S_CMD:   if (rx_valid && !cmd_ok) begin tx_load = 1'b1; tx_data = 8'h45; end
            S_BUS:   if (is_wr) begin tx_load = 1'b1; tx_data = 8'h4B; end
            S_RWAIT: begin tx_load = 1'b1; tx_data = data_i[31:24]; end
            S_RESP:  if (tx_done && resp_left != 2'd0) begin
                         tx_load = 1'b1;
                         tx_data = resp_buf[31:24];
                     end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CMD;
            byte_cnt  <= 2'd0;
            resp_left <= 2'd0;
            is_wr     <= 1'b0;
            addr_sh   <= 32'd0;
            data_sh   <= 32'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            resp_buf  <= 32'd0;
            to_cnt    <= 32'd0;
        end else begin
            case (state)
                S_CMD: begin
                    if (rx_valid) begin
                        state    <= cmd_ok ? S_ADDR : S_ERR;
                        is_wr    <= (rx_sh == 8'h57);
                        byte_cnt <= 2'd0;
                        to_cnt   <= 32'd0;
                    end
                end
                S_ADDR, S_WDATA: begin
                    if (rx_ferr) begin
                        state <= S_CMD;
                    end else if (rx_valid) begin
                        to_cnt   <= 32'd0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == S_ADDR) begin
                            addr_sh <= {addr_sh[23:0], rx_sh};
                            if (byte_cnt == 2'd3) begin
                                if (is_wr) begin
                                    state <= S_WDATA;
                                end else begin
                                    addr_q <= {addr_sh[23:0], rx_sh};
                                    state  <= S_BUS;
                                end
                            end
                        end else begin
                            data_sh <= {data_sh[23:0], rx_sh};
                            if (byte_cnt == 2'd3) begin
                                addr_q <= addr_sh;
                                data_q <= {data_sh[23:0], rx_sh};
                                state  <= S_BUS;
                            end
                        end
                    end else if (to_cnt == TIMEOUT_CYC - 32'd1) begin
                        state <= S_CMD;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                S_BUS: begin
                    state     <= is_wr ? S_RESP : S_RWAIT;
                    resp_left <= 2'd0;
                end
                S_RWAIT: begin
                    resp_buf  <= {data_i[23:0], 8'h00};
                    resp_left <= 2'd3;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (tx_done) begin
                        if (resp_left == 2'd0) begin
                            state <= S_CMD;
                        end else begin
                            resp_buf  <= {resp_buf[23:0], 8'h00};
                            resp_left <= resp_left - 2'd1;
                        end
                    end
                end
                S_ERR:   if (tx_done) state <= S_CMD;
                default: state <= S_CMD;
            endcase
        end
    end

    assign we_o   = (state == S_BUS) && is_wr;
    assign rd_o   = (state == S_BUS) && !is_wr;
    assign sel_o  = (state == S_BUS) ? 4'hF : 4'h0;
    assign busy_o = (state != S_CMD);
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: drives serial frames, decodes tx_pin and
// watches the bus strobes against hand-computed expectations.
module tb_uart_bus_master;

    localparam int unsigned BAUD = 8;
    localparam int unsigned TMO  = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_pin;
    logic        tx_pin;
    logic [31:0] addr_o, data_o, data_i;
    logic [3:0]  sel_o;
    logic        we_o, rd_o, busy_o;

    uart_bus_master #(
        .BAUD_DIV    (BAUD),
        .TIMEOUT_CYC (32'(TMO))
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_pin (rx_pin),
        .tx_pin (tx_pin),
        .addr_o (addr_o),
        .data_o (data_o),
        .sel_o  (sel_o),
        .we_o   (we_o),
        .rd_o   (rd_o),
        .data_i (data_i),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          we_cnt = 0, rd_cnt = 0, sel_bad = 0;
    logic [31:0] we_addr, we_data, rd_addr;
    logic [3:0]  we_sel, rd_sel;
    logic [31:0] rd_val;
    logic [7:0]  tx_bytes[$];
    int          tx_t[$];
    logic [7:0]  tm_b;
    int          tm_t0;
    int          bw, br, bt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_o) begin
            we_cnt  = we_cnt + 1;
            we_addr = addr_o;
            we_data = data_o;
            we_sel  = sel_o;
        end
        if (rd_o) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = addr_o;
            rd_sel  = sel_o;
        end
        if (!we_o && !rd_o && sel_o != 4'h0) sel_bad = sel_bad + 1;
    end

    // Read data is only valid on the cycle right after rd_o
    initial begin
        data_i = 32'h0;
        forever begin
            @(negedge clk);
            if (rd_o) begin
                @(posedge clk);
                #1 data_i = rd_val;
                @(posedge clk);
                #1 data_i = 32'h0;
            end
        end
    end

    // Serial decoder for tx_pin, sampling mid-bit
    initial begin
        forever begin
            @(negedge clk);
            if (tx_pin == 1'b0) begin
                tm_t0 = cyc;
                repeat (BAUD / 2) @(negedge clk);
                if (tx_pin == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BAUD) @(negedge clk);
                        tm_b[i] = tx_pin;
                    end
                    repeat (BAUD) @(negedge clk);
                    if (tx_pin == 1'b1) begin
                        tx_bytes.push_back(tm_b);
                        tx_t.push_back(tm_t0);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_pin = bits[i];
            repeat (BAUD) @(negedge clk);
        end
        rx_pin = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy_o), 32'h0);
    endtask

    task automatic snap();
        bw = we_cnt;
        br = rd_cnt;
        bt = tx_bytes.size();
    endtask

    task automatic check_strobes(input string tag, input int we_exp, input int rd_exp);
        check({tag, "_we"}, 32'(we_cnt - bw), 32'(we_exp));
        check({tag, "_rd"}, 32'(rd_cnt - br), 32'(rd_exp));
    endtask

    task automatic check_tx(input string tag, input int idx, input logic [7:0] exp);
        if (tx_bytes.size() > bt + idx) check(tag, 32'(tx_bytes[bt + idx]), 32'(exp));
        else check(tag, 32'hFFFF_FFFF, 32'(exp));
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        rx_pin = 1'b1;
        rd_val = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_pin), 32'h1);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_sel", 32'(sel_o), 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_strb", 32'({we_o, rd_o}), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write
        snap();
        send_byte(8'h57, 1'b1);
        send_word(32'h0000_1000);
        send_word(32'hDEAD_BEEF);
        check("wr_busy", 32'(busy_o), 32'h1);
        wait_idle("wr_idle");
        check_strobes("wr", 1, 0);
        check("wr_addr", we_addr, 32'h0000_1000);
        check("wr_data", we_data, 32'hDEAD_BEEF);
        check("wr_sel", 32'(we_sel), 32'hF);
        check("wr_ntx", 32'(tx_bytes.size() - bt), 32'd1);
        check_tx("wr_k", 0, 8'h4B);
        check("wr_sel_idle", 32'(sel_o), 32'h0);

        // Read
        snap();
        rd_val = 32'h1234_5678;
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_1004);
        wait_idle("rd_idle");
        check_strobes("rd", 0, 1);
        check("rd_addr", rd_addr, 32'h0000_1004);
        check("rd_sel", 32'(rd_sel), 32'hF);
        check("rd_ntx", 32'(tx_bytes.size() - bt), 32'd4);
        check_tx("rd_b0", 0, 8'h12);
        check_tx("rd_b1", 1, 8'h34);
        check_tx("rd_b2", 2, 8'h56);
        check_tx("rd_b3", 3, 8'h78);
        for (int i = 0; i < 3; i++) begin
            if (tx_t.size() > bt + i + 1) check("rd_gap", 32'(tx_t[bt + i + 1] - tx_t[bt + i]),
                                               32'(10 * BAUD));
        end
        check("rd_hold_data", data_o, 32'hDEAD_BEEF);
        check("rd_hold_addr", addr_o, 32'h0000_1004);

        // Unknown command
        snap();
        send_byte(8'h33, 1'b1);
        check("err_busy", 32'(busy_o), 32'h1);
        wait_idle("err_idle");
        check_strobes("err", 0, 0);
        check("err_ntx", 32'(tx_bytes.size() - bt), 32'd1);
        check_tx("err_e", 0, 8'h45);

        // Inter-byte timeout
        snap();
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TMO - 40) @(negedge clk);
        check("to_before", 32'(busy_o), 32'h1);
        repeat (60) @(negedge clk);
        check("to_after", 32'(busy_o), 32'h0);
        check_strobes("to", 0, 0);
        check("to_ntx", 32'(tx_bytes.size() - bt), 32'd0);
        snap();
        rd_val = 32'hA5A5_5A5A;
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_0008);
        wait_idle("to_rd_idle");
        check_strobes("to_rd", 0, 1);
        check("to_rd_addr", rd_addr, 32'h0000_0008);
        check_tx("to_rd_b0", 0, 8'hA5);
        check_tx("to_rd_b3", 3, 8'h5A);

        // Framing error, then a one-cycle glitch
        snap();
        send_byte(8'h52, 1'b0);
        repeat (30) @(negedge clk);
        check("fe_busy", 32'(busy_o), 32'h0);
        @(negedge clk) rx_pin = 1'b0;
        @(negedge clk) rx_pin = 1'b1;
        repeat (20 * BAUD) @(negedge clk);
        check("gl_busy", 32'(busy_o), 32'h0);
        check_strobes("fe", 0, 0);
        check("fe_ntx", 32'(tx_bytes.size() - bt), 32'd0);

        // Reset during the second response byte
        snap();
        rd_val = 32'hCAFE_F00D;
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_2000);
        n = 0;
        while (tx_bytes.size() == bt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_tx("rr_b0", 0, 8'hCA);
        repeat (2 * BAUD) @(negedge clk);
        check("rr_mid_busy", 32'(busy_o), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rr_tx", 32'(tx_pin), 32'h1);
        check("rr_busy", 32'(busy_o), 32'h0);
        check("rr_addr", addr_o, 32'h0);
        check("rr_data", data_o, 32'h0);
        check("rr_sel", 32'(sel_o), 32'h0);
        rst = 1'b0;
        repeat (12 * BAUD) @(negedge clk);
        snap();
        send_byte(8'h57, 1'b1);
        send_word(32'h0000_2000);
        send_word(32'h1122_3344);
        wait_idle("rr_wr_idle");
        check_strobes("rr_wr", 1, 0);
        check("rr_wr_addr", we_addr, 32'h0000_2000);
        check("rr_wr_data", we_data, 32'h1122_3344);
        check_tx("rr_wr_k", 0, 8'h4B);

        check("sel_outside_bus", 32'(sel_bad), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
